lzw_fwd_sched: RTL and testbench
================================

# lzw_fwd_sched

Frame scheduler for the LZW forward transmit path. It arbitrates between the dictionary-update source and the header/payload/compressed-data FIFOs, then sequences each frame as header followed by raw or compressed payload. It enforces the GMII inter-frame gap and issues a recovery reset to the framer datapath when a granted segment stalls. It sits between the FIFO request lines and the forward framer's output multiplexer.

## Interface
- IFG_CYCLES, 12, minimum idle cycles between segments, counted from `seg_done`.
- TIMEOUT_CYCLES, 4096, maximum cycles a granted segment may last before recovery.
- RST_CYCLES, 8, width of the `O_lzw_forward_rst` pulse.
- I_sys_clk  in  1  system clock, 250 MHz.
- I_sys_rst  in  1  asynchronous, active-low reset.
- I_fifo_head_req / I_fifo_pload_req / I_fifo_cmprs_req / I_dict_req  in  1 each  segment-ready requests, level.
- I_head_no_pload  in  1  current header has no payload; sampled with `seg_done` in HEAD.
- I_cmprs_en  in  1  payload source select (1 = compressed FIFO); latched on entry to HEAD.
- I_seg_done  in  1  single-cycle pulse from the datapath at the last byte of the granted segment.
- O_fifo_head_ack / O_fifo_pload_ack / O_fifo_cmprs_ack / O_dict_ack  out  1 each  grants, level, one-hot or all zero.
- O_src_sel  out  3  output mux select: 0 none, 1 head, 2 pload, 3 cmprs, 4 dict.
- O_lzw_forward_rst  out  1  active-high datapath recovery reset.
- O_frame_cnt  out  16  completed frames, wraps.
- O_timeout_cnt  out  8  recovery events, saturates at 255.

## Operation
- States:
  - IDLE: waits for a request.
  - HEAD: header segment granted.
  - PLOAD: raw payload granted.
  - CMPRS: compressed payload granted.
  - DICT: dictionary update granted.
  - IFG: inter-frame gap.
  - RECOV: datapath recovery reset.
- Grant selection in IDLE:
  - `I_dict_req` goes to DICT; `I_fifo_head_req` goes to HEAD.
  - Both requests present: dict wins, unless the previous grant was DICT. A `last_dict` flag prevents dict from starving head.
- Transitions out of a granted state:
  - HEAD + `seg_done`: `I_head_no_pload`=1 → IFG, frame complete. Otherwise → CMPRS if the latched `cmprs_en`=1, else → PLOAD.
  - HEAD → data state has no gap; the data ack may wait on its FIFO request, and the timeout covers that stall.
  - PLOAD/CMPRS + `seg_done` → IFG, frame complete.
  - DICT + `seg_done` → IFG.
- IFG lasts exactly IFG_CYCLES cycles, then goes to IDLE. Requests are ignored during IFG.
- Timeout counter:
  - Cleared on entry to HEAD, PLOAD, CMPRS or DICT; increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES-1 without `seg_done` → RECOV, and `O_timeout_cnt` +1 (saturating).
  - The partial frame is not counted.
- RECOV: `O_lzw_forward_rst`=1 for RST_CYCLES cycles with all acks low, then → IFG.
- A dictionary update never preempts a frame in progress. Header and payload of one frame are always contiguous.
- `O_frame_cnt` increments on frame complete; it wraps 0xFFFF → 0.

## Timing
- All outputs are registered. Reset values: acks 0, `O_src_sel`=0, `O_lzw_forward_rst`=0, counters 0, state IDLE, `last_dict`=0.
- Request sampled high in IDLE at cycle N → ack and `O_src_sel` valid at N+1.
- `seg_done` at cycle M:
  - Current ack falls at M+1.
  - HEAD→data: the next ack rises at M+1 on the same edge.
  - Otherwise IFG occupies M+1..M+IFG_CYCLES, and the earliest next ack is at M+IFG_CYCLES+2.
- `seg_done` in the same cycle as timeout expiry: done wins and no recovery occurs.
- `seg_done` in IDLE, IFG or RECOV is ignored.
- Requests dropping while granted do not revoke the grant; only `seg_done` or timeout ends a segment.
- Reset asserted mid-segment: all outputs return to reset values immediately (asynchronous). Leaving reset is synchronous to `I_sys_clk`.

## Structure
- Shared package `lzw_fwd_pkg`: state encoding, `O_src_sel` codes (SRC_NONE..SRC_DICT), default IFG/TIMEOUT/RST constants.
- One natural sub-module, `lzw_fwd_tmr`: a loadable down-counter with expiry flag, instanced for both the IFG and RECOV durations. The timeout uses a separate up-counter in the top.
- Everything else (FSM, grant decode, statistics) lives in `lzw_fwd_sched`.

## Test plan
- Head req with `no_pload`=0, `cmprs_en`=0:
  - Head ack at N+1; `seg_done` at M → pload ack and `src_sel`=2 at M+1.
  - Second `seg_done` → 12 idle cycles; `O_frame_cnt`=1.
- Dict and head requested together, with both held high throughout: dict granted first, then head (`last_dict`), then dict again.
- Head with `no_pload`=1: IFG directly after the header; `O_frame_cnt`=1; no payload ack ever asserted.
- CMPRS granted and `seg_done` withheld 4096 cycles:
  - Acks drop and `O_lzw_forward_rst` is high for exactly 8 cycles.
  - Then 12 IFG cycles; `O_timeout_cnt`=1, `O_frame_cnt` unchanged.
  - Repeat the case with `seg_done` on the expiry cycle: no reset.
- Async reset asserted mid-PLOAD: all acks 0 and `src_sel`=0 without a clock edge. After release, a head req is granted at N+1.
- Wrap and saturation: preload via 65536 no-payload frames → `O_frame_cnt`=0; 256 timeouts → `O_timeout_cnt` holds at 255.

Source files
------------

// File: rtl/lzw_fwd_pkg.sv
// Shared definitions for the LZW forward frame scheduler.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
// Contents: FSM state encoding, output-mux select codes, default timing constants.
package lzw_fwd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAD  = 3'd1,
    ST_PLOAD = 3'd2,
    ST_CMPRS = 3'd3,
    ST_DICT  = 3'd4,
    ST_IFG   = 3'd5,
    ST_RECOV = 3'd6
  } state_e;

  // Output multiplexer select codes driven on O_src_sel.
  localparam logic [2:0] SRC_NONE  = 3'd0;
  localparam logic [2:0] SRC_HEAD  = 3'd1;
  localparam logic [2:0] SRC_PLOAD = 3'd2;
  localparam logic [2:0] SRC_CMPRS = 3'd3;
  localparam logic [2:0] SRC_DICT  = 3'd4;

  localparam int unsigned IFG_CYCLES_DEF     = 12;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;
  localparam int unsigned RST_CYCLES_DEF     = 8;

  // States in which a segment owns the datapath and the stall timeout runs.
  function automatic logic is_granted(input state_e s);
    return (s == ST_HEAD) || (s == ST_PLOAD) || (s == ST_CMPRS) || (s == ST_DICT);
  endfunction

endpackage

// File: rtl/lzw_fwd_tmr.sv
// Loadable down-counter with expiry flag; times the IFG and RECOV phases.
// Latency: value loaded on a clock edge is visible next cycle; expired = (count == 0).
// Backpressure: none, counts freely once loaded and parks at zero.
// Ports: clk/rst_n, load + load_val (load wins over decrement), expired (combinational from flop).
module lzw_fwd_tmr
  import lzw_fwd_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/lzw_fwd_sched.sv
// Frame scheduler: grants dict/header, sequences header -> payload, enforces IFG, recovers stalls.
// Latency: request in IDLE at cycle N -> ack/src_sel at N+1; all outputs registered.
// Backpressure: a granted segment holds until seg_done or timeout; data ack waits on its FIFO request.
// Ports: I_sys_clk/I_sys_rst (async active-low); FIFO/dict request levels in, one-hot acks out;
//        O_src_sel mux select, O_lzw_forward_rst recovery pulse, frame and timeout statistics.
module lzw_fwd_sched
  import lzw_fwd_pkg::*;
#(
  parameter int unsigned IFG_CYCLES     = IFG_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned RST_CYCLES     = RST_CYCLES_DEF
) (
  input  logic        I_sys_clk,
  input  logic        I_sys_rst,
  input  logic        I_fifo_head_req,
  input  logic        I_fifo_pload_req,
  input  logic        I_fifo_cmprs_req,
  input  logic        I_dict_req,
  input  logic        I_head_no_pload,
  input  logic        I_cmprs_en,
  input  logic        I_seg_done,
  output logic        O_fifo_head_ack,
  output logic        O_fifo_pload_ack,
  output logic        O_fifo_cmprs_ack,
  output logic        O_dict_ack,
  output logic [2:0]  O_src_sel,
  output logic        O_lzw_forward_rst,
  output logic [15:0] O_frame_cnt,
  output logic [7:0]  O_timeout_cnt
);

  localparam int unsigned TMR_MAX = (IFG_CYCLES > RST_CYCLES) ? IFG_CYCLES : RST_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic              last_dict_q, last_dict_d;
  logic              cmprs_en_q, cmprs_en_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]        timeout_cnt_q, timeout_cnt_d;
  logic [2:0]        src_sel_q, src_sel_d;
  logic [3:0]        ack_q, ack_d;          // {dict, cmprs, pload, head}
  logic              fwd_rst_q, fwd_rst_d;

  logic frame_done;
  logic tmo_evt;
  logic tmo_hit;
  logic ifg_load, ifg_expired;
  logic recov_load, recov_expired;

  assign tmo_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Both phase timers are loaded with N-1 on the entry edge so the phase lasts N cycles.
  assign ifg_load   = (state_d == ST_IFG)   && (state_q != ST_IFG);
  assign recov_load = (state_d == ST_RECOV) && (state_q != ST_RECOV);

  lzw_fwd_tmr #(.W(TMR_W)) u_ifg_tmr (
    .clk      (I_sys_clk),
    .rst_n    (I_sys_rst),
    .load     (ifg_load),
    .load_val (TMR_W'(IFG_CYCLES - 1)),
    .expired  (ifg_expired)
  );

  lzw_fwd_tmr #(.W(TMR_W)) u_recov_tmr (
    .clk      (I_sys_clk),
    .rst_n    (I_sys_rst),
    .load     (recov_load),
    .load_val (TMR_W'(RST_CYCLES - 1)),
    .expired  (recov_expired)
  );

  // State register.
  always_ff @(posedge I_sys_clk or negedge I_sys_rst) begin
    if (!I_sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. seg_done is checked before the timeout so a done on the expiry cycle wins.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    tmo_evt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Dict wins a tie unless it had the previous grant, so head cannot starve.
        if (I_dict_req && !(I_fifo_head_req && last_dict_q)) begin
          state_d = ST_DICT;
        end else if (I_fifo_head_req) begin
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (I_seg_done) begin
          if (I_head_no_pload) begin
            state_d    = ST_IFG;
            frame_done = 1'b1;
          end else begin
            state_d = cmprs_en_q ? ST_CMPRS : ST_PLOAD;
          end
        end else if (tmo_hit) begin
          state_d = ST_RECOV;
          tmo_evt = 1'b1;
        end
      end
      ST_PLOAD, ST_CMPRS: begin
        if (I_seg_done) begin
          state_d    = ST_IFG;
          frame_done = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_RECOV;
          tmo_evt = 1'b1;
        end
      end
      ST_DICT: begin
        if (I_seg_done) begin
          state_d = ST_IFG;
        end else if (tmo_hit) begin
          state_d = ST_RECOV;
          tmo_evt = 1'b1;
        end
      end
      ST_IFG: begin
        if (ifg_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_RECOV: begin
        if (recov_expired) begin
          state_d = ST_IFG;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with state_q.
  // A data ack waits for its FIFO request, then stays up until the segment ends.
  always_comb begin
    src_sel_d = SRC_NONE;
    ack_d     = 4'b0000;
    fwd_rst_d = 1'b0;
    case (state_d)
      ST_HEAD:  begin src_sel_d = SRC_HEAD;  ack_d[0] = 1'b1; end
      ST_PLOAD: begin src_sel_d = SRC_PLOAD; ack_d[1] = I_fifo_pload_req | ack_q[1]; end
      ST_CMPRS: begin src_sel_d = SRC_CMPRS; ack_d[2] = I_fifo_cmprs_req | ack_q[2]; end
      ST_DICT:  begin src_sel_d = SRC_DICT;  ack_d[3] = 1'b1; end
      ST_RECOV: fwd_rst_d = 1'b1;
      default:  ;
    endcase
  end

  // Arbitration history, payload-source latch, stall timer and statistics.
  always_comb begin
    last_dict_d = last_dict_q;
    cmprs_en_d  = cmprs_en_q;
    if (state_q == ST_IDLE && state_d == ST_DICT) begin
      last_dict_d = 1'b1;
    end else if (state_q == ST_IDLE && state_d == ST_HEAD) begin
      last_dict_d = 1'b0;
      cmprs_en_d  = I_cmprs_en;
    end

    to_cnt_d = to_cnt_q;
    if (is_granted(state_d) && (state_d != state_q)) begin
      to_cnt_d = '0;
    end else if (is_granted(state_q)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    frame_cnt_d   = frame_cnt_q + 16'(frame_done);
    timeout_cnt_d = timeout_cnt_q;
    if (tmo_evt && (timeout_cnt_q != 8'hFF)) begin
      timeout_cnt_d = timeout_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rst) begin
    if (!I_sys_rst) begin
      last_dict_q   <= 1'b0;
      cmprs_en_q    <= 1'b0;
      to_cnt_q      <= '0;
      frame_cnt_q   <= 16'd0;
      timeout_cnt_q <= 8'd0;
      src_sel_q     <= SRC_NONE;
      ack_q         <= 4'b0000;
      fwd_rst_q     <= 1'b0;
    end else begin
      last_dict_q   <= last_dict_d;
      cmprs_en_q    <= cmprs_en_d;
      to_cnt_q      <= to_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      src_sel_q     <= src_sel_d;
      ack_q         <= ack_d;
      fwd_rst_q     <= fwd_rst_d;
    end
  end

  assign O_fifo_head_ack   = ack_q[0];
  assign O_fifo_pload_ack  = ack_q[1];
  assign O_fifo_cmprs_ack  = ack_q[2];
  assign O_dict_ack        = ack_q[3];
  assign O_src_sel         = src_sel_q;
  assign O_lzw_forward_rst = fwd_rst_q;
  assign O_frame_cnt       = frame_cnt_q;
  assign O_timeout_cnt     = timeout_cnt_q;

endmodule

// File: tb/tb_lzw_fwd_sched.sv
// Self-checking bench for lzw_fwd_sched: grant scoreboard plus per-scenario inline checks.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: FIFO request levels driven directly by each scenario.
`timescale 1ns/1ps
module tb_lzw_fwd_sched;
  import lzw_fwd_pkg::*;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic rst_n;
  logic head_req, pload_req, cmprs_req, dict_req, no_pload, cmprs_en, seg_done;
  logic head_ack, pload_ack, cmprs_ack, dict_ack, fwd_rst;
  logic [2:0]  src_sel;
  logic [15:0] frame_cnt;
  logic [7:0]  tmo_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int exp_frames = 0;
  int exp_tmo = 0;
  logic [2:0] exp_q[$];

  lzw_fwd_sched dut (
    .I_sys_clk        (clk),
    .I_sys_rst        (rst_n),
    .I_fifo_head_req  (head_req),
    .I_fifo_pload_req (pload_req),
    .I_fifo_cmprs_req (cmprs_req),
    .I_dict_req       (dict_req),
    .I_head_no_pload  (no_pload),
    .I_cmprs_en       (cmprs_en),
    .I_seg_done       (seg_done),
    .O_fifo_head_ack  (head_ack),
    .O_fifo_pload_ack (pload_ack),
    .O_fifo_cmprs_ack (cmprs_ack),
    .O_dict_ack       (dict_ack),
    .O_src_sel        (src_sel),
    .O_lzw_forward_rst(fwd_rst),
    .O_frame_cnt      (frame_cnt),
    .O_timeout_cnt    (tmo_cnt)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_done();
    seg_done = 1'b1;
    @(negedge clk);
    seg_done = 1'b0;
  endtask

  // Bounded wait for any grant; waited = falling edges elapsed (limit 200).
  task automatic wait_grant(output int waited);
    waited = 0;
    while (src_sel == SRC_NONE && waited < 200) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic pop_exp(output logic [2:0] e);
    if (exp_q.size() == 0) e = 3'h7;
    else e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; head_req = 0; pload_req = 0; cmprs_req = 0; dict_req = 0;
    no_pload = 0; cmprs_en = 0; seg_done = 0;
    ticks(3);
    cmp_cnt++; if ({head_ack, pload_ack, cmprs_ack, dict_ack} !== 4'b0000) begin err_cnt++; $display("FAIL reset_acks got=%b exp=0000", {head_ack, pload_ack, cmprs_ack, dict_ack}); end
    cmp_cnt++; if (src_sel !== SRC_NONE) begin err_cnt++; $display("FAIL reset_src_sel got=%0d exp=0", src_sel); end
    cmp_cnt++; if (fwd_rst !== 1'b0) begin err_cnt++; $display("FAIL reset_fwd_rst got=%b exp=0", fwd_rst); end
    cmp_cnt++; if (frame_cnt !== 16'd0 || tmo_cnt !== 8'd0) begin err_cnt++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", frame_cnt, tmo_cnt); end
    rst_n = 1'b1;
    ticks(3);
    cmp_cnt++; if (src_sel !== SRC_NONE) begin err_cnt++; $display("FAIL idle_no_req got=%0d exp=0", src_sel); end
  endtask

  task automatic test_head_pload();
    int w; logic [2:0] e;
    head_req = 1; no_pload = 0; cmprs_en = 0; pload_req = 0;
    exp_q.push_back(SRC_HEAD);
    tick();
    head_req = 0;
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e) begin err_cnt++; $display("FAIL hp_head_latency got=%0d exp=%0d", src_sel, e); end
    cmp_cnt++; if (head_ack !== 1'b1) begin err_cnt++; $display("FAIL hp_head_ack got=%b exp=1", head_ack); end
    ticks(3);
    cmp_cnt++; if (head_ack !== 1'b1) begin err_cnt++; $display("FAIL hp_no_revoke got=%b exp=1", head_ack); end
    exp_q.push_back(SRC_PLOAD);
    pulse_done();
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e) begin err_cnt++; $display("FAIL hp_pload_sel got=%0d exp=%0d", src_sel, e); end
    cmp_cnt++; if ({head_ack, pload_ack} !== 2'b00) begin err_cnt++; $display("FAIL hp_ack_wait got=%b exp=00", {head_ack, pload_ack}); end
    pload_req = 1;
    tick();
    cmp_cnt++; if (pload_ack !== 1'b1) begin err_cnt++; $display("FAIL hp_pload_ack got=%b exp=1", pload_ack); end
    pload_req = 0;
    ticks(2);
    cmp_cnt++; if (pload_ack !== 1'b1) begin err_cnt++; $display("FAIL hp_pload_hold got=%b exp=1", pload_ack); end
    head_req = 1; no_pload = 1;
    pulse_done();
    exp_frames++;
    exp_q.push_back(SRC_HEAD);
    cmp_cnt++; if (frame_cnt !== 16'(exp_frames)) begin err_cnt++; $display("FAIL hp_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
    cmp_cnt++; if ({src_sel, pload_ack} !== 4'b0000) begin err_cnt++; $display("FAIL hp_ack_fall got=%b exp=0000", {src_sel, pload_ack}); end
    wait_grant(w);
    cmp_cnt++; if (w !== 13) begin err_cnt++; $display("FAIL hp_ifg_gap got=%0d exp=13", w); end
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e) begin err_cnt++; $display("FAIL hp_regrant got=%0d exp=%0d", src_sel, e); end
    head_req = 0;
    pulse_done();
    exp_frames++;
    ticks(16);
    no_pload = 0;
  endtask

  task automatic test_dict_head();
    int w; logic [2:0] e;
    dict_req = 1; head_req = 1; no_pload = 1;
    exp_q.push_back(SRC_DICT); exp_q.push_back(SRC_HEAD); exp_q.push_back(SRC_DICT);
    wait_grant(w);
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e || dict_ack !== 1'b1 || w !== 1) begin err_cnt++; $display("FAIL dh_first got=%0d/%b/%0d exp=%0d/1/1", src_sel, dict_ack, w, e); end
    pulse_done();
    wait_grant(w);
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e || head_ack !== 1'b1 || w !== 13) begin err_cnt++; $display("FAIL dh_second got=%0d/%b/%0d exp=%0d/1/13", src_sel, head_ack, w, e); end
    pulse_done();
    exp_frames++;
    wait_grant(w);
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e || dict_ack !== 1'b1) begin err_cnt++; $display("FAIL dh_third got=%0d/%b exp=%0d/1", src_sel, dict_ack, e); end
    dict_req = 0; head_req = 0;
    pulse_done();
    ticks(16);
    cmp_cnt++; if (frame_cnt !== 16'(exp_frames)) begin err_cnt++; $display("FAIL dh_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
    no_pload = 0;
  endtask

  task automatic test_no_pload();
    int w; logic [2:0] e; logic seen;
    head_req = 1; no_pload = 1; cmprs_en = 1; pload_req = 1; cmprs_req = 1;
    exp_q.push_back(SRC_HEAD);
    wait_grant(w);
    head_req = 0;
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e) begin err_cnt++; $display("FAIL np_head got=%0d exp=%0d", src_sel, e); end
    pulse_done();
    exp_frames++;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (pload_ack || cmprs_ack || src_sel != SRC_NONE) seen = 1;
      tick();
    end
    cmp_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL np_payload_ack got=%b exp=0", seen); end
    cmp_cnt++; if (frame_cnt !== 16'(exp_frames)) begin err_cnt++; $display("FAIL np_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
    no_pload = 0; cmprs_en = 0; pload_req = 0; cmprs_req = 0;
  endtask

  task automatic test_cmprs_timeout();
    int w; int n; int m; int bad; logic [2:0] e;
    head_req = 1; no_pload = 0; cmprs_en = 1; cmprs_req = 1;
    exp_q.push_back(SRC_HEAD); exp_q.push_back(SRC_CMPRS);
    wait_grant(w);
    head_req = 0; cmprs_en = 0;
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e) begin err_cnt++; $display("FAIL to_head got=%0d exp=%0d", src_sel, e); end
    pulse_done();
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e || cmprs_ack !== 1'b1) begin err_cnt++; $display("FAIL to_cmprs got=%0d/%b exp=%0d/1", src_sel, cmprs_ack, e); end
    n = 0;
    while (src_sel == SRC_CMPRS && n < 5000) begin n++; tick(); end
    cmp_cnt++; if (n !== 4096) begin err_cnt++; $display("FAIL to_seg_len got=%0d exp=4096", n); end
    exp_tmo++;
    cmp_cnt++; if (tmo_cnt !== 8'(exp_tmo)) begin err_cnt++; $display("FAIL to_tmo_cnt got=%0d exp=%0d", tmo_cnt, exp_tmo); end
    head_req = 1; no_pload = 1;
    exp_q.push_back(SRC_HEAD);
    m = 0; bad = 0;
    while (fwd_rst && m < 20) begin
      if ({head_ack, pload_ack, cmprs_ack, dict_ack} != 4'b0000 || src_sel != SRC_NONE) bad++;
      m++; tick();
    end
    cmp_cnt++; if (m !== 8) begin err_cnt++; $display("FAIL to_rst_width got=%0d exp=8", m); end
    cmp_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL to_acks_in_recov got=%0d exp=0", bad); end
    wait_grant(w);
    cmp_cnt++; if (w !== 13) begin err_cnt++; $display("FAIL to_ifg_gap got=%0d exp=13", w); end
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e) begin err_cnt++; $display("FAIL to_regrant got=%0d exp=%0d", src_sel, e); end
    cmp_cnt++; if (frame_cnt !== 16'(exp_frames)) begin err_cnt++; $display("FAIL to_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
    head_req = 0;
    pulse_done();
    exp_frames++;
    ticks(16);
    no_pload = 0; cmprs_req = 0;
  endtask

  task automatic test_done_on_expiry();
    int w; logic [2:0] e; logic seen;
    head_req = 1; no_pload = 0; cmprs_en = 1; cmprs_req = 1;
    exp_q.push_back(SRC_HEAD); exp_q.push_back(SRC_CMPRS);
    wait_grant(w);
    head_req = 0; cmprs_en = 0;
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e) begin err_cnt++; $display("FAIL de_head got=%0d exp=%0d", src_sel, e); end
    pulse_done();
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e) begin err_cnt++; $display("FAIL de_cmprs got=%0d exp=%0d", src_sel, e); end
    ticks(4095);
    cmp_cnt++; if (src_sel !== SRC_CMPRS) begin err_cnt++; $display("FAIL de_still_granted got=%0d exp=3", src_sel); end
    pulse_done();
    exp_frames++;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (fwd_rst) seen = 1;
      tick();
    end
    cmp_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL de_no_recov got=%b exp=0", seen); end
    cmp_cnt++; if (tmo_cnt !== 8'(exp_tmo)) begin err_cnt++; $display("FAIL de_tmo_cnt got=%0d exp=%0d", tmo_cnt, exp_tmo); end
    cmp_cnt++; if (frame_cnt !== 16'(exp_frames)) begin err_cnt++; $display("FAIL de_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
    cmprs_req = 0;
  endtask

  task automatic test_async_reset();
    int w; logic [2:0] e;
    head_req = 1; no_pload = 0; cmprs_en = 0; pload_req = 1;
    exp_q.push_back(SRC_HEAD); exp_q.push_back(SRC_PLOAD);
    wait_grant(w);
    head_req = 0;
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e) begin err_cnt++; $display("FAIL ar_head got=%0d exp=%0d", src_sel, e); end
    pulse_done();
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e || pload_ack !== 1'b1) begin err_cnt++; $display("FAIL ar_pload got=%0d/%b exp=%0d/1", src_sel, pload_ack, e); end
    #0.5 rst_n = 1'b0;
    #0.5;
    cmp_cnt++; if ({head_ack, pload_ack, cmprs_ack, dict_ack, fwd_rst} !== 5'b0 || src_sel !== SRC_NONE) begin err_cnt++; $display("FAIL ar_async_clear got=%b/%0d exp=00000/0", {head_ack, pload_ack, cmprs_ack, dict_ack, fwd_rst}, src_sel); end
    cmp_cnt++; if (frame_cnt !== 16'd0 || tmo_cnt !== 8'd0) begin err_cnt++; $display("FAIL ar_counters got=%0d/%0d exp=0/0", frame_cnt, tmo_cnt); end
    exp_frames = 0; exp_tmo = 0; pload_req = 0;
    ticks(2);
    rst_n = 1'b1;
    tick();
    head_req = 1; no_pload = 1;
    exp_q.push_back(SRC_HEAD);
    wait_grant(w);
    pop_exp(e);
    cmp_cnt++; if (src_sel !== e || w !== 1) begin err_cnt++; $display("FAIL ar_post_grant got=%0d/%0d exp=%0d/1", src_sel, w, e); end
    head_req = 0;
    pulse_done();
    exp_frames++;
    ticks(16);
    no_pload = 0;
  endtask

  task automatic test_wrap_sat();
    int w; int n; logic [2:0] e;
    force dut.frame_cnt_q = 16'hFFFE;
    #0.5 release dut.frame_cnt_q;
    exp_frames = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      head_req = 1; no_pload = 1;
      exp_q.push_back(SRC_HEAD);
      wait_grant(w);
      head_req = 0;
      pop_exp(e);
      cmp_cnt++; if (src_sel !== e) begin err_cnt++; $display("FAIL ws_head got=%0d exp=%0d", src_sel, e); end
      pulse_done();
      exp_frames = (exp_frames + 1) & 16'hFFFF;
      cmp_cnt++; if (frame_cnt !== 16'(exp_frames)) begin err_cnt++; $display("FAIL ws_frame_wrap got=%0h exp=%0h", frame_cnt, exp_frames); end
      ticks(14);
    end
    no_pload = 0;
    @(negedge clk);
    force dut.timeout_cnt_q = 8'd254;
    #0.5 release dut.timeout_cnt_q;
    exp_tmo = 254;
    for (int k = 0; k < 2; k++) begin
      dict_req = 1;
      exp_q.push_back(SRC_DICT);
      wait_grant(w);
      dict_req = 0;
      pop_exp(e);
      cmp_cnt++; if (src_sel !== e) begin err_cnt++; $display("FAIL ws_dict got=%0d exp=%0d", src_sel, e); end
      n = 0;
      while (src_sel == SRC_DICT && n < 5000) begin n++; tick(); end
      cmp_cnt++; if (n !== 4096 || fwd_rst !== 1'b1) begin err_cnt++; $display("FAIL ws_dict_timeout got=%0d/%b exp=4096/1", n, fwd_rst); end
      exp_tmo = (exp_tmo < 255) ? exp_tmo + 1 : 255;
      cmp_cnt++; if (tmo_cnt !== 8'(exp_tmo)) begin err_cnt++; $display("FAIL ws_tmo_sat got=%0d exp=%0d", tmo_cnt, exp_tmo); end
      ticks(25);
    end
  endtask

  initial begin
    test_reset();
    test_head_pload();
    test_dict_head();
    test_no_pload();
    test_cmprs_timeout();
    test_done_on_expiry();
    test_async_reset();
    test_wrap_sat();
    cmp_cnt++; if (exp_q.size() != 0) begin err_cnt++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
